// File: rtl/rr_arb_dec4_ctrl.sv
// ---------------------------------------------------------------------------
// rr_arb_dec4_ctrl
//   Four-way round-robin arbiter with a bounded hold time. A requester keeps
//   the grant while it requests. After MAX_HOLD consecutive cycles it is
//   preempted, but only if someone else is waiting. The priority pointer
//   moves to one past the most recent winner, so the scan order rotates.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles while others wait (1..15)
//
// Ports
//   clk      in   sole clock, rising edge
//   reset    in   synchronous active-high reset
//   req      in   [3:0] request vector, bit i = requester i
//   gnt      out  [3:0] registered one-hot grant, 0000 when idle
//   gnt_idx  out  [1:0] registered owner index, 0 when idle
//   gnt_val  out  registered "grant held" flag
// ---------------------------------------------------------------------------
module rr_arb_dec4_ctrl #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_val
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr,   w_ptr_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [3:0] r_cnt,   w_cnt_nxt;
  logic [3:0] r_gnt,   w_gnt_nxt;
  logic [1:0] r_gnt_idx, w_gnt_idx_nxt;
  logic       r_gnt_val, w_gnt_val_nxt;

  logic [3:0] w_others;
  logic [2:0] w_pick_all;   // {found, index} over all requests
  logic [2:0] w_pick_oth;   // {found, index} excluding the current owner

  // First set bit of mask scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                         input logic [1:0] ptr);
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    found = 1'b0;
    win   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (mask[idx] && !found) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  assign w_others   = req & ~(4'b0001 << r_owner);
  assign w_pick_all = rr_pick(req, r_ptr);
  assign w_pick_oth = rr_pick(w_others, r_ptr);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = 4'b0000;
    w_gnt_idx_nxt = 2'd0;
    w_gnt_val_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_pick_all[2]) begin
          w_state_nxt = BUSY;
          w_owner_nxt = w_pick_all[1:0];
          w_cnt_nxt   = 4'd1;
          w_ptr_nxt   = w_pick_all[1:0] + 2'd1;
        end
      end
      BUSY: begin
        if (req[r_owner]) begin
          if (r_cnt < HOLD_MAX) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_pick_oth[2]) begin
            // Hold budget spent and someone is waiting: preempt.
            w_owner_nxt = w_pick_oth[1:0];
            w_cnt_nxt   = 4'd1;
            w_ptr_nxt   = w_pick_oth[1:0] + 2'd1;
          end else begin
            w_cnt_nxt = HOLD_MAX;
          end
        end else if (w_pick_oth[2]) begin
          // Owner released; hand off on the same edge, no idle bubble.
          w_owner_nxt = w_pick_oth[1:0];
          w_cnt_nxt   = 4'd1;
          w_ptr_nxt   = w_pick_oth[1:0] + 2'd1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are registered copies of the next-state owner decode.
    if (w_state_nxt == BUSY) begin
      w_gnt_nxt     = 4'b0001 << w_owner_nxt;
      w_gnt_idx_nxt = w_owner_nxt;
      w_gnt_val_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= 2'd0;
      r_owner   <= 2'd0;
      r_cnt     <= 4'd0;
      r_gnt     <= 4'b0000;
      r_gnt_idx <= 2'd0;
      r_gnt_val <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_gnt_val <= w_gnt_val_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign gnt_val = r_gnt_val;

endmodule

// File: tb/tb_rr_arb_dec4_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_dec4_ctrl
//   Directed bench for rr_arb_dec4_ctrl (MAX_HOLD = 4). Each step drives req
//   and reset, advances one rising edge, and checks the registered grant
//   outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_rr_arb_dec4_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_val;

  int n_vec  = 0;
  int n_miss = 0;

  rr_arb_dec4_ctrl #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_val (gnt_val)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic rst_v, input logic [3:0] req_v);
    reset = rst_v;
    req   = req_v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] e_gnt,
                     input logic [1:0] e_idx, input logic e_val);
    logic [6:0] got;
    logic [6:0] exp;
    got = {gnt, gnt_idx, gnt_val};
    exp = {e_gnt, e_idx, e_val};
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: observed gnt=%b idx=%0d val=%b, expected gnt=%b idx=%0d val=%b",
             tag, gnt, gnt_idx, gnt_val, e_gnt, e_idx, e_val);
    end
  endtask

  initial begin
    logic [1:0] o;
    reset = 1'b1;
    req   = 4'b0000;

    // Reset, then idle with no requests
    cyc(1'b1, 4'b0000); chk("reset", 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'b0000); chk("idle_norq", 4'b0000, 2'd0, 1'b0);
    end

    // Single requester held: grant stays, count saturates, no drop
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'b0001); chk("hold_sat", 4'b0001, 2'd0, 1'b1);
    end
    // Saturated owner, requester 1 arrives: immediate preempt
    cyc(1'b0, 4'b0011); chk("sat_preempt", 4'b0010, 2'd1, 1'b1);
    cyc(1'b0, 4'b0000); chk("release_idle", 4'b0000, 2'd0, 1'b0);

    // Full load rotation from ptr=0, including wrap 3 -> 0
    cyc(1'b1, 4'b0000); chk("reset2", 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      o = 2'((i / 4) % 4);
      cyc(1'b0, 4'b1111); chk("rotate", 4'b0001 << o, o, 1'b1);
    end
    // Now owner 0, cnt 1, ptr 1

    // Handoff without bubble, then release to idle
    cyc(1'b0, 4'b0101); chk("keep_owner0", 4'b0001, 2'd0, 1'b1);
    cyc(1'b0, 4'b0100); chk("handoff_2", 4'b0100, 2'd2, 1'b1);
    cyc(1'b0, 4'b0000); chk("drop_idle", 4'b0000, 2'd0, 1'b0);
    // ptr = 3

    // Owner 1 releases leaving ptr=2; 1011 -> index 3 wins by rotation
    cyc(1'b0, 4'b0010); chk("grant_1", 4'b0010, 2'd1, 1'b1);
    cyc(1'b0, 4'b0000); chk("rel_1", 4'b0000, 2'd0, 1'b0);
    cyc(1'b0, 4'b1011); chk("rot_3", 4'b1000, 2'd3, 1'b1);

    // Hand off to 2, then reset mid-grant with full load
    cyc(1'b0, 4'b0100); chk("handoff_2b", 4'b0100, 2'd2, 1'b1);
    cyc(1'b1, 4'b1111); chk("reset_mid", 4'b0000, 2'd0, 1'b0);
    cyc(1'b0, 4'b1111); chk("post_reset", 4'b0001, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rr_arb_dec4_ctrl.md
RR_ARB_DEC4_CTRL -- requirements
Module: rr_arb_dec4_ctrl

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive cycles one owner keeps the grant while others wait; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  request vector; bit i high = requester i wants the shared resource.
REQ-005 gnt  output  4  one-hot grant, the 2-to-4 decode of gnt_idx when gnt_val=1, else 0000.
REQ-006 gnt_idx  output  2  index of the current owner; 0 when gnt_val=0.
REQ-007 gnt_val  output  1  high while any requester holds the grant.

Function
REQ-008 All outputs SHALL be registered; a req value sampled at edge t SHALL affect outputs from edge t onward, i.e. visible one cycle after it is applied.
REQ-009 State SHALL comprise: FSM {IDLE, BUSY}, priority pointer ptr (2 bits), owner index, hold counter cnt (4 bits).
REQ-010 Winner selection SHALL scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4) and pick the first with its candidate req bit high.
REQ-011 IDLE with req=0000 SHALL remain IDLE with gnt=0000, gnt_val=0.
REQ-012 IDLE with any req high SHALL go to BUSY, owner=winner, cnt=1, ptr=winner+1 mod 4.
REQ-013 BUSY with req[owner]=1 and cnt<MAX_HOLD SHALL keep the owner and increment cnt.
REQ-014 BUSY with req[owner]=1, cnt=MAX_HOLD and another req bit high SHALL preempt: new owner = winner among bits other than owner, cnt=1, ptr=new owner+1 mod 4.
REQ-015 BUSY with req[owner]=1, cnt=MAX_HOLD and no other request SHALL keep the owner with cnt saturated at MAX_HOLD.
REQ-016 BUSY with req[owner]=0 and another req bit high SHALL hand off on the same edge with no idle cycle: new owner = winner excluding old owner, cnt=1, ptr updated per REQ-014.
REQ-017 BUSY with req[owner]=0 and no other request SHALL go to IDLE, gnt=0000, gnt_val=0, ptr unchanged.
REQ-018 gnt SHALL never have more than one bit set; gnt SHALL equal the 2-to-4 decode of gnt_idx whenever gnt_val=1.
REQ-019 Pointer wrap-around SHALL be modulo 4 (owner 3 -> ptr 0).
REQ-020 A requester whose request is granted SHALL see gnt bit high until it drops req or is preempted; the arbiter SHALL NOT grant a requester whose req bit is low at the deciding edge.

Reset
REQ-021 reset=1 at an edge SHALL force IDLE, ptr=0, owner=0, cnt=0, gnt=0000, gnt_idx=0, gnt_val=0, overriding all other transitions, including mid-grant.
REQ-022 The first edge with reset=0 SHALL arbitrate normally per REQ-011/012 using ptr=0.

Verification
REQ-023 Reset, req=0000 for 3 cycles -> gnt=0000, gnt_idx=0, gnt_val=0 every cycle.
REQ-024 req=0001 held 8 cycles (MAX_HOLD=4) -> gnt=0001, gnt_idx=0, gnt_val=1 from the cycle after req rises, continuously (saturation, no drop).
REQ-025 req=1111 held (MAX_HOLD=4) -> gnt 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again (wrap).
REQ-026 Owner 0 granted, then req changes 0101 -> 0100 -> next cycle gnt=0100, gnt_idx=2, no gnt_val=0 bubble; then req=0000 -> gnt=0000, gnt_val=0.
REQ-027 After owner 1 releases (ptr=2), req=1011 -> gnt=1000 (index 3 beats 0 and 1 by rotation).
REQ-028 reset asserted one cycle while gnt=0100 and req=1111 -> next cycle gnt=0000, gnt_val=0; reset deasserted with req=1111 -> following cycle gnt=0001.
